wb_write_queue: RTL and testbench

- Write-side client of the 32x32 register file.
- Merges register writebacks from the in-order pipeline (source 0) and from a long-latency unit such as the divider or load return (source 1) into the file's single write port.
- Entries are buffered in order in a small FIFO and drained one per cycle onto we/waddr/wdata.
- Two lookup ports let ID forward data that is still queued.

---
 rtl/wb_write_queue.sv | 137 +++++++++++++
 tb/tb_wb_write_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Write-back merge queue for the 32x32 register file: two sources into one write port,
// in-order FIFO drain, with two lookup ports so ID can forward still-queued data.
module wb_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s0_valid,
    input  logic [AW-1:0]                s0_waddr,
    input  logic [DW-1:0]                s0_wdata,
    output logic                         s0_stall,
    input  logic                         s1_valid,
    output logic                         s1_ready,
    input  logic [AW-1:0]                s1_waddr,
    input  logic [DW-1:0]                s1_wdata,
    output logic                         we,
    output logic [AW-1:0]                waddr,
    output logic [DW-1:0]                wdata,
    input  logic [AW-1:0]                lk1_raddr,
    output logic                         lk1_hit,
    output logic [DW-1:0]                lk1_data,
    input  logic [AW-1:0]                lk2_raddr,
    output logic                         lk2_hit,
    output logic [DW-1:0]                lk2_data,
    output logic                         overflow,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          overflow_q, overflow_d;

    logic [CW-1:0] free_c;
    logic          s0_enq_c, s1_enq_c, pop_c;
    logic [PW-1:0] s1_slot_c;

    // Flow control is computed from the registered count only; a same-cycle pop is never credited.
    always_comb begin
        free_c    = CW'(DEPTH) - count_q;
        s0_stall  = rst | (free_c < CW'(2));
        s1_ready  = ~rst & (free_c > CW'(s0_valid));
        s0_enq_c  = s0_valid & ~s0_stall & (s0_waddr != '0);
        s1_enq_c  = s1_valid & s1_ready & (s1_waddr != '0);
        pop_c     = (count_q != '0);
        s1_slot_c = tail_q + PW'(s0_enq_c);
    end

    always_comb begin
        head_d     = head_q + PW'(pop_c);
        tail_d     = tail_q + PW'(s0_enq_c) + PW'(s1_enq_c);
        count_d    = count_q + CW'(s0_enq_c) + CW'(s1_enq_c) - CW'(pop_c);
        we_d       = pop_c;
        waddr_d    = pop_c ? addr_q[head_q] : waddr_q;
        wdata_d    = pop_c ? data_q[head_q] : wdata_q;
        overflow_d = overflow_q | (s0_valid & s0_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; validity is tracked by head/count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (s0_enq_c) begin
            addr_q[tail_q] <= s0_waddr;
            data_q[tail_q] <= s0_wdata;
        end
        if (s1_enq_c) begin
            addr_q[s1_slot_c] <= s1_waddr;
            data_q[s1_slot_c] <= s1_wdata;
        end
    end

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        lk1_hit  = 1'b0;
        lk1_data = '0;
        lk2_hit  = 1'b0;
        lk2_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((lk1_raddr != '0) && (addr_q[idx] == lk1_raddr)) begin
                    lk1_hit  = 1'b1;
                    lk1_data = data_q[idx];
                end
                if ((lk2_raddr != '0) && (addr_q[idx] == lk2_raddr)) begin
                    lk2_hit  = 1'b1;
                    lk2_data = data_q[idx];
                end
            end
        end
        if (rst) begin
            lk1_hit  = 1'b0;
            lk1_data = '0;
            lk2_hit  = 1'b0;
            lk2_data = '0;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign overflow = overflow_q;
    assign count    = count_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized scoreboard bench for wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s1_valid;
    logic [4:0]  s0_waddr, s1_waddr, lk1_raddr, lk2_raddr;
    logic [31:0] s0_wdata, s1_wdata;
    logic        s0_stall, s1_ready, we, lk1_hit, lk2_hit, overflow;
    logic [4:0]  waddr;
    logic [31:0] wdata, lk1_data, lk2_data;
    logic [2:0]  count;

    wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_waddr(s0_waddr), .s0_wdata(s0_wdata), .s0_stall(s0_stall),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_waddr(s1_waddr), .s1_wdata(s1_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .lk1_raddr(lk1_raddr), .lk1_hit(lk1_hit), .lk1_data(lk1_data),
        .lk2_raddr(lk2_raddr), .lk2_hit(lk2_hit), .lk2_data(lk2_data),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: queued entries, expected port write stream, output register, sticky flag.
    ent_t        mq[$];
    ent_t        sb[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mlook(input logic [4:0] ra, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (ra != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == ra) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        int          free;
        logic        h;
        logic [31:0] d;
        free = DEPTH - mq.size();
        chk("s0_stall", 32'(s0_stall), rst ? 32'd1 : 32'(free < 2));
        chk("s1_ready", 32'(s1_ready), rst ? 32'd0 : 32'((free - int'(s0_valid)) >= 1));
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("we", 32'(we), 32'(m_we));
        chk("waddr", 32'(waddr), 32'(m_waddr));
        chk("wdata", wdata, m_wdata);
        mlook(lk1_raddr, h, d);
        if (rst) begin h = 1'b0; d = '0; end
        chk("lk1_hit", 32'(lk1_hit), 32'(h));
        chk("lk1_data", lk1_data, d);
        mlook(lk2_raddr, h, d);
        if (rst) begin h = 1'b0; d = '0; end
        chk("lk2_hit", 32'(lk2_hit), 32'(h));
        chk("lk2_data", lk2_data, d);
    endtask

    task automatic model_edge();
        int free;
        if (rst) begin
            mq.delete();
            sb.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ovf = 1'b0;
            return;
        end
        free = DEPTH - mq.size();
        if (mq.size() > 0) begin
            ent_t e;
            e = mq.pop_front();
            m_we = 1'b1; m_waddr = e.a; m_wdata = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (s0_valid && free < 2) m_ovf = 1'b1;
        else if (s0_valid && s0_waddr != 5'd0) begin
            mq.push_back({s0_waddr, s0_wdata});
            sb.push_back({s0_waddr, s0_wdata});
        end
        if (s1_valid && (free - int'(s0_valid)) >= 1 && s1_waddr != 5'd0) begin
            mq.push_back({s1_waddr, s1_wdata});
            sb.push_back({s1_waddr, s1_wdata});
        end
    endtask

    task automatic step(input logic r,
                        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] l1, input logic [4:0] l2);
        @(negedge clk);
        rst = r;
        s0_valid = v0; s0_waddr = a0; s0_wdata = d0;
        s1_valid = v1; s1_waddr = a1; s1_wdata = d1;
        lk1_raddr = l1; lk2_raddr = l2;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    // Monitor: every port write must match the next expected entry in order.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && we === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_we", 32'(we), 32'd0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("port_waddr", 32'(waddr), 32'(e.a));
                    chk("port_wdata", wdata, e.d);
                end
            end
        end
    end

    function automatic logic [4:0] pick_addr();
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
            return mq[$urandom_range(0, mq.size() - 1)].a;
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd7);
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 1'b1; s0_waddr = 5'd3; s0_wdata = 32'hDEAD;
        s1_valid = 1'b0; s1_waddr = '0; s1_wdata = '0;
        lk1_raddr = 5'd3; lk2_raddr = '0;
        repeat (2) @(posedge clk);

        // Reset with a pending s0 request on reg 3.
        step(1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b1, 5'd3, 32'hBEEF, 5'd3, 5'd3);
        step(1'b1, 1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        idle(3);

        // Single write into empty queue.
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(4);

        // Same-cycle s0/s1 to the same register: s1 is younger.
        step(1'b0, 1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle(4);

        // Hold s1_valid with s0 idle: wrap-around across many entries.
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + i), 32'h100 + 32'(i), 5'(1 + i), 5'(i));
        idle(6);

        // Fill to three then violate the stall.
        step(1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd9, 5'd10);
        step(1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd11, 5'd12);
        step(1'b0, 1'b1, 5'd13, 32'hD0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd12);
        idle(6);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // Address 0 writes are accepted but never queued.
        step(1'b0, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
        idle(3);

        // Random traffic with occasional resets; s0 obeys the stall.
        for (int i = 0; i < 600; i++) begin
            logic r, v0, v1;
            int   free;
            free = DEPTH - mq.size();
            r  = ($urandom_range(0, 99) == 0);
            v0 = ($urandom_range(0, 2) != 0) && (free >= 2);
            v1 = ($urandom_range(0, 1) == 1);
            step(r, v0, 5'($urandom_range(0, 31)), $urandom(),
                 v1, 5'($urandom_range(0, 31)), $urandom(), pick_addr(), pick_addr());
        end

        // Drain with a bounded cycle budget.
        for (int i = 0; i < 20 && (mq.size() > 0 || m_we); i++) idle(1);
        idle(2);
        chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("drain_model_empty", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
